cpu_ctrl_fsm: RTL

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_fsm.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle CPU control FSM, Moore-decoded datapath controls (optional macro CPU_FSM_PERF_EN)
module cpu_ctrl_fsm #(
   parameter int MEM_WAIT = 1,
   parameter int TYPE_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [TYPE_W-1:0] instr_type,
   input  logic              cond_true,
   input  logic              resume,
   output logic              PC_enable,
   output logic              PC_load,
   output logic              IR_enable,
   output logic              R_enable,
   output logic              ALU_Bus_enable,
   output logic              reg_read,
   output logic              WrtBrm_en,
   output logic              halted,
   output logic              illegal,
   output logic [3:0]        state_o,
   output logic [15:0]       instr_count
);

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_DECODE     = 4'd1,
      S_EXEC_R     = 4'd2,
      S_STORE      = 4'd3,
      S_STORE_HOLD = 4'd4,
      S_LOAD       = 4'd5,
      S_LOAD_WAIT  = 4'd6,
      S_LOAD_WB    = 4'd7,
      S_BRANCH     = 4'd8,
      S_JUMP       = 4'd9,
      S_HALT       = 4'd10
   } state_t;

   // LOAD_WAIT lasts while the counter walks from MEM_WAIT-1 down to 0
   localparam logic [3:0] WAIT_INIT = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_wait;
   logic        r_cond;
   logic        r_illegal;
   logic        w_set_illegal;
   logic        w_cap_cond;

   // State, wait counter, captured branch condition and sticky illegal flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_FETCH;
         r_wait    <= 4'd0;
         r_cond    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_LOAD) begin
            r_wait <= WAIT_INIT;
         end else if (r_state == S_LOAD_WAIT && r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
         end
         if (w_cap_cond) begin
            r_cond <= cond_true;
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   // Next-state selection and Moore output decode from the registered state
   always_comb begin
      w_next         = S_FETCH;
      w_set_illegal  = 1'b0;
      w_cap_cond     = 1'b0;
      PC_enable      = 1'b0;
      PC_load        = 1'b0;
      IR_enable      = 1'b0;
      R_enable       = 1'b0;
      ALU_Bus_enable = 1'b0;
      reg_read       = 1'b0;
      WrtBrm_en      = 1'b0;
      halted         = 1'b0;
      case (r_state)
         S_FETCH: begin
            IR_enable      = 1'b1;
            ALU_Bus_enable = 1'b1;
            w_next         = S_DECODE;
         end
         S_DECODE: begin
            PC_enable      = 1'b1;
            ALU_Bus_enable = 1'b1;
            if (instr_type == TYPE_W'(0)) begin
               w_next = S_EXEC_R;
            end else if (instr_type == TYPE_W'(1)) begin
               w_next = S_STORE;
            end else if (instr_type == TYPE_W'(2)) begin
               w_next = S_LOAD;
            end else if (instr_type == TYPE_W'(3)) begin
               w_next     = S_BRANCH;
               w_cap_cond = 1'b1;
            end else if (instr_type == TYPE_W'(4)) begin
               w_next = S_JUMP;
            end else if (instr_type == TYPE_W'(5)) begin
               w_next = S_HALT;
            end else begin
               w_next        = S_FETCH;
               w_set_illegal = 1'b1;
            end
         end
         S_EXEC_R: begin
            R_enable       = 1'b1;
            ALU_Bus_enable = 1'b1;
         end
         S_STORE: begin
            reg_read  = 1'b1;
            WrtBrm_en = 1'b1;
            w_next    = S_STORE_HOLD;
         end
         S_STORE_HOLD: begin
            ALU_Bus_enable = 1'b1;
         end
         S_LOAD: begin
            reg_read = 1'b1;
            w_next   = (MEM_WAIT > 0) ? S_LOAD_WAIT : S_LOAD_WB;
         end
         S_LOAD_WAIT: begin
            reg_read = 1'b1;
            w_next   = (r_wait == 4'd0) ? S_LOAD_WB : S_LOAD_WAIT;
         end
         S_LOAD_WB: begin
            R_enable = 1'b1;
            reg_read = 1'b1;
         end
         S_BRANCH: begin
            PC_load = r_cond;
         end
         S_JUMP: begin
            PC_load = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
            w_next = resume ? S_FETCH : S_HALT;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   assign illegal = r_illegal;
   assign state_o = r_state;

`ifdef CPU_FSM_PERF_EN
   logic        w_retire;
   logic [15:0] r_count;

   // Only completed instructions count; illegal aborts from DECODE do not
   assign w_retire = (r_state == S_EXEC_R) || (r_state == S_STORE_HOLD) ||
                     (r_state == S_LOAD_WB) || (r_state == S_BRANCH) ||
                     (r_state == S_JUMP) || (r_state == S_HALT && resume);

   // Retired-instruction counter, wraps naturally at 16 bits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= 16'd0;
      end else if (w_retire) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign instr_count = r_count;
`else
   assign instr_count = 16'd0;
`endif

endmodule
